// File: rtl/init_dual_port_bram.sv
// Simple dual-port block RAM (one write port, one read port) with a
// power-up / on-demand initialisation sweep, byte-enabled writes and a
// configurable read-during-write result and output latency.
module init_dual_port_bram #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter string       INIT_MODE  = "RF",
   parameter string       RDW_MODE   = "WRITE_FIRST",
   parameter bit          OUT_REG    = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_req,
   output logic                    busy,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic [DATA_WIDTH-1:0]   din,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    dout_valid
);

   localparam int unsigned           NBYTE       = DATA_WIDTH / 8;
   localparam int unsigned           DEPTH       = 2 ** ADDR_WIDTH;
   localparam bit                    INIT_NONE   = (INIT_MODE == "NONE");
   localparam bit                    INIT_RF     = (INIT_MODE == "RF");
   localparam bit                    WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t                  state_d, state_q;
   logic [ADDR_WIDTH-1:0]   cnt_d, cnt_q;
   logic                    rd_valid_d, rd_valid_q;
   logic [DATA_WIDTH-1:0]   rd_data_d, rd_data_q;

   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [NBYTE-1:0]        mem_be;
   logic [DATA_WIDTH-1:0]   rd_old;
   logic [DATA_WIDTH-1:0]   rd_merged;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    rd_fire;
   logic                    flush;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   assign busy = (state_q == ST_INIT);

   // Next-state and sweep counter: the counter wraps naturally at the top address.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (init_req && !INIT_NONE) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Write-port mux: the sweep owns the port in INIT, the user owns it in READY.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = waddr;
      mem_wdata = din;
      mem_be    = wbe;
      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_addr  = cnt_q;
         mem_wdata = INIT_RF ? DATA_WIDTH'(cnt_q) : '0;
         mem_be    = '1;
      end else if (we) begin
         mem_we = 1'b1;
      end
   end

   // Read side: collision merge, pipeline flush whenever the next state is INIT.
   always_comb begin
      rd_old = mem[raddr];
      for (int k = 0; k < NBYTE; k++) begin
         rd_merged[8*k +: 8] = wbe[k] ? din[8*k +: 8] : rd_old[8*k +: 8];
      end
      rd_word    = (WRITE_FIRST && we && (waddr == raddr)) ? rd_merged : rd_old;
      rd_fire    = re && (state_q == ST_READY);
      flush      = (state_d == ST_INIT);
      rd_valid_d = rd_fire && !flush;
      rd_data_d  = rd_fire ? rd_word : rd_data_q;
   end

   // Byte-enabled memory array write.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset so it maps onto block RAM; rst leaves contents intact.
      if (mem_we) begin
         for (int k = 0; k < NBYTE; k++) begin
            if (mem_be[k]) begin
               mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
         end
      end
   end

   // State, counter and first read stage registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q    <= INIT_NONE ? ST_READY : ST_INIT;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout_d, dout_q;
      logic                  dout_valid_d, dout_valid_q;

      // Optional output stage: loads only on a valid first-stage result.
      always_comb begin
         dout_valid_d = rd_valid_q && !flush;
         dout_d       = rd_valid_q ? rd_data_q : dout_q;
      end

      // Output stage registers.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
         end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
         end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
   end else begin : g_no_out_reg
      assign dout       = rd_data_q;
      assign dout_valid = rd_valid_q;
   end

endmodule
